// File: rtl/faims_drive_pkg.sv
// Shared types and default widths for the FAIMS HV/coil driver.
package faims_pkg;

  localparam int FAIMS_CW  = 16;
  localparam int FAIMS_SKW = 8;
  localparam int FAIMS_DW  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } coil_state_t;

  typedef struct packed {
    logic [FAIMS_CW-1:0]  period;
    logic [FAIMS_CW-1:0]  pulse;
    logic [FAIMS_DW-1:0]  dead;
    logic [FAIMS_SKW-1:0] skip;
    logic [FAIMS_CW-1:0]  work;
  } faims_par_t;

endpackage

// File: rtl/faims_drive_if.sv
// Parameter-load bus between the register interface (master) and faims_drive (slave).
interface faims_drive_if #(
  parameter int CW  = faims_pkg::FAIMS_CW,
  parameter int SKW = faims_pkg::FAIMS_SKW,
  parameter int DW  = faims_pkg::FAIMS_DW
) ();

  logic           i_load;
  logic [CW-1:0]  i_parPeriod;
  logic [CW-1:0]  i_parPulseLen;
  logic [DW-1:0]  i_parDead;
  logic [SKW-1:0] i_parSkip;
  logic [CW-1:0]  i_parWork;
  logic           o_paramErr;

  modport master (
    output i_load, i_parPeriod, i_parPulseLen, i_parDead, i_parSkip, i_parWork,
    input  o_paramErr
  );

  modport slave (
    input  i_load, i_parPeriod, i_parPulseLen, i_parDead, i_parSkip, i_parWork,
    output o_paramErr
  );

endinterface

// File: rtl/faims_drive_coil_ctl.sv
// Coil H-bridge FSM: skip/work/guard counters and alternating polarity, all outputs registered.
module faims_coil_ctl
  import faims_pkg::*;
#(
  parameter int CW  = FAIMS_CW,
  parameter int SKW = FAIMS_SKW,
  parameter int DW  = FAIMS_DW
) (
  input  logic           CLK,
  input  logic           i_reset_n,
  input  logic           i_run,
  input  logic           i_periodStart,
  input  logic [CW-1:0]  i_work,
  input  logic [DW-1:0]  i_dead,
  input  logic [SKW-1:0] i_skip,
  output logic           o_coilAU,
  output logic           o_coilAD,
  output logic           o_coilBU,
  output logic           o_coilBD,
  output logic           o_coilOverrun
);

  localparam logic [CW-1:0]  CW_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [SKW-1:0] SK_ONE = {{(SKW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]  DW_ONE = {{(DW-1){1'b0}}, 1'b1};

  coil_state_t    state_q;
  logic           pol_a_q;
  logic [SKW-1:0] skip_q;
  logic [CW-1:0]  work_q;
  logic [DW-1:0]  guard_q;
  logic           au_q, ad_q, bu_q, bd_q, ovr_q;

  // Coil FSM; gate outputs are driven from the state being entered so they line up with the phase outputs
  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      pol_a_q <= 1'b0;
      skip_q  <= '0;
      work_q  <= '0;
      guard_q <= '0;
      au_q    <= 1'b0;
      ad_q    <= 1'b0;
      bu_q    <= 1'b0;
      bd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (!i_run) begin
      state_q <= IDLE;
      skip_q  <= i_skip;
      au_q    <= 1'b0;
      ad_q    <= 1'b0;
      bu_q    <= 1'b0;
      bd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      au_q  <= 1'b0;
      ad_q  <= 1'b0;
      bu_q  <= 1'b0;
      bd_q  <= 1'b0;
      ovr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_periodStart) begin
            if (skip_q == '0) begin
              skip_q <= i_skip;
              if (i_work != '0) begin
                pol_a_q <= ~pol_a_q;
                work_q  <= i_work - CW_ONE;
                state_q <= ACTIVE;
                au_q    <= ~pol_a_q;
                bd_q    <= ~pol_a_q;
                ad_q    <= pol_a_q;
                bu_q    <= pol_a_q;
              end
            end else begin
              skip_q <= skip_q - SK_ONE;
            end
          end
        end
        ACTIVE: begin
          if (work_q == '0) begin
            guard_q <= i_dead;
            state_q <= GUARD;
          end else begin
            work_q <= work_q - CW_ONE;
            au_q   <= pol_a_q;
            bd_q   <= pol_a_q;
            ad_q   <= ~pol_a_q;
            bu_q   <= ~pol_a_q;
          end
        end
        GUARD: begin
          if ((guard_q == '0) || (guard_q == DW_ONE)) begin
            state_q <= IDLE;
          end else begin
            guard_q <= guard_q - DW_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A slot that lands while busy is reported and consumed; the running on-time is left alone
      if (i_periodStart && (state_q != IDLE)) begin
        if (skip_q == '0) begin
          skip_q <= i_skip;
          ovr_q  <= (i_work != '0);
        end else begin
          skip_q <= skip_q - SK_ONE;
        end
      end
    end
  end

  assign o_coilAU      = au_q;
  assign o_coilAD      = ad_q;
  assign o_coilBU      = bu_q;
  assign o_coilBD      = bd_q;
  assign o_coilOverrun = ovr_q;

endmodule

// File: rtl/faims_drive.sv
// FAIMS HV switch pair and coil driver with double-buffered parameters.
// FAIMS_DRIVE_PARCHECK_EN enables load validation and the o_paramErr strobe.
module faims_drive
  import faims_pkg::*;
#(
  parameter int CW  = FAIMS_CW,
  parameter int SKW = FAIMS_SKW,
  parameter int DW  = FAIMS_DW
) (
  input  logic         CLK,
  input  logic         i_reset_n,
  input  logic         i_enable,
  faims_drive_if.slave par_if,
  output logic         o_faimsUp,
  output logic         o_faimsDown,
  output logic         o_coilAU,
  output logic         o_coilAD,
  output logic         o_coilBU,
  output logic         o_coilBD,
  output logic         o_periodStart,
  output logic         o_coilOverrun
);

  localparam logic [CW-1:0] CW_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0]  ph_q, ph_d;
  logic [CW-1:0]  act_period_q, act_pulse_q, act_work_q;
  logic [DW-1:0]  act_dead_q;
  logic [SKW-1:0] act_skip_q;
  logic [CW-1:0]  pend_period_q, pend_pulse_q, pend_work_q;
  logic [DW-1:0]  pend_dead_q;
  logic [SKW-1:0] pend_skip_q;
  logic           act_valid_q, pend_valid_q;
  logic           up_q, dn_q, ps_q;

  logic           run_s, ps_s, last_s, copy_s, load_ok_s, up_s, dn_s;
  logic [CW:0]    ph_x, per_x, pl_x, dead_x;

  assign run_s  = i_enable & act_valid_q;
  assign ps_s   = run_s & (ph_q == '0);
  assign last_s = run_s & (ph_q == (act_period_q - CW_ONE));
  // New parameters take effect on the wrap so a whole period, phase 0 included, uses one set
  assign copy_s = pend_valid_q & (~run_s | last_s);

  assign ph_x   = {1'b0, ph_q};
  assign per_x  = {1'b0, act_period_q};
  assign pl_x   = {1'b0, act_pulse_q};
  assign dead_x = {{(CW+1-DW){1'b0}}, act_dead_q};

  assign up_s = run_s & (ph_x >= dead_x) & (ph_x < pl_x);
  assign dn_s = run_s & (ph_x >= (pl_x + dead_x)) & (ph_x < per_x) & ~up_s;

`ifdef FAIMS_DRIVE_PARCHECK_EN
  logic        err_q;
  logic [CW:0] in_per_x, in_pl_x, in_dead_x;

  assign in_per_x  = {1'b0, par_if.i_parPeriod};
  assign in_pl_x   = {1'b0, par_if.i_parPulseLen};
  assign in_dead_x = {{(CW+1-DW){1'b0}}, par_if.i_parDead};
  assign load_ok_s = (par_if.i_parPeriod > CW_ONE) & (in_dead_x < in_pl_x) &
                     ((in_pl_x + in_dead_x) < in_per_x);

  // One-cycle strobe for a rejected load
  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= par_if.i_load & ~load_ok_s;
    end
  end

  assign par_if.o_paramErr = err_q;
`else
  assign load_ok_s         = 1'b1;
  assign par_if.o_paramErr = 1'b0;
`endif

  // Phase counter next state
  always_comb begin
    ph_d = '0;
    if (!run_s) begin
      ph_d = '0;
    end else if (last_s) begin
      ph_d = '0;
    end else begin
      ph_d = ph_q + CW_ONE;
    end
  end

  // Phase, parameter double buffer and registered HV drives
  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ph_q          <= '0;
      act_period_q  <= '0;
      act_pulse_q   <= '0;
      act_dead_q    <= '0;
      act_skip_q    <= '0;
      act_work_q    <= '0;
      pend_period_q <= '0;
      pend_pulse_q  <= '0;
      pend_dead_q   <= '0;
      pend_skip_q   <= '0;
      pend_work_q   <= '0;
      act_valid_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      up_q          <= 1'b0;
      dn_q          <= 1'b0;
      ps_q          <= 1'b0;
    end else begin
      ph_q <= ph_d;
      up_q <= up_s;
      dn_q <= dn_s;
      ps_q <= ps_s;
      if (copy_s) begin
        act_period_q <= pend_period_q;
        act_pulse_q  <= pend_pulse_q;
        act_dead_q   <= pend_dead_q;
        act_skip_q   <= pend_skip_q;
        act_work_q   <= pend_work_q;
        act_valid_q  <= 1'b1;
      end
      if (par_if.i_load && load_ok_s) begin
        pend_period_q <= par_if.i_parPeriod;
        pend_pulse_q  <= par_if.i_parPulseLen;
        pend_dead_q   <= par_if.i_parDead;
        pend_skip_q   <= par_if.i_parSkip;
        pend_work_q   <= par_if.i_parWork;
        pend_valid_q  <= 1'b1;
      end else if (copy_s) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  faims_coil_ctl #(
    .CW  (CW),
    .SKW (SKW),
    .DW  (DW)
  ) u_coil (
    .CLK           (CLK),
    .i_reset_n     (i_reset_n),
    .i_run         (run_s),
    .i_periodStart (ps_s),
    .i_work        (act_work_q),
    .i_dead        (act_dead_q),
    .i_skip        (act_skip_q),
    .o_coilAU      (o_coilAU),
    .o_coilAD      (o_coilAD),
    .o_coilBU      (o_coilBU),
    .o_coilBD      (o_coilBD),
    .o_coilOverrun (o_coilOverrun)
  );

  assign o_faimsUp     = up_q;
  assign o_faimsDown   = dn_q;
  assign o_periodStart = ps_q;

endmodule

// File: doc/faims_drive.md
# faims_drive

Parametrised FAIMS high-voltage and coil driver, successor to the fixed 16-bit FAIMS waveform block. Generates the complementary HV switch pair (`o_faimsUp`/`o_faimsDown`) with programmable dead time, plus the alternating-polarity H-bridge coil drive for the DCDC converter on every (skip+1)-th period. Parameters are double-buffered and applied only at period boundaries. Sits between the Raspberry Pi register interface and the HV switch / coil gate-driver pins.

## Interface
- `CW`, 16: width of period, pulse and work counters.
- `SKW`, 8: width of the skip count.
- `DW`, 8: width of the dead-time count.
- `CLK` in 1: system clock.
- `i_reset_n` in 1: reset; asynchronous assertion, active-low.
- `i_enable` in 1: run when high; all drive outputs low when low.
- `i_load` in 1: one-cycle strobe that captures all `i_par*` into the pending set.
- `i_parPeriod` in CW: period P in cycles; must be ≥2.
- `i_parPulseLen` in CW: phase at which the Up pulse ends.
- `i_parDead` in DW: dead time D in cycles.
- `i_parSkip` in SKW: number of periods skipped between coil activations.
- `i_parWork` in CW: coil on-time W in cycles; 0 means no coil drive.
- `o_faimsUp`, `o_faimsDown` out 1: HV switch drives.
- `o_coilAU`, `o_coilAD`, `o_coilBU`, `o_coilBD` out 1: H-bridge gates.
- `o_periodStart` out 1: one-cycle strobe on phase 0.
- `o_coilOverrun` out 1: one-cycle strobe when a coil activation slot is missed.
- `o_paramErr` out 1: one-cycle strobe when a load is rejected.

## Operation
- **Reset.** All outputs, counters, the skip count and the active/pending parameter sets are 0. The active set is invalid. The polarity register is B. Outputs stay low until the first accepted load, even when `i_enable` is high.
- **Loading.**
  - A load on `i_load` is valid only if all of these hold: P ≥ 2, D < PulseLen, and PulseLen + D < P.
  - An invalid load is discarded and raises `o_paramErr`.
  - A valid load becomes pending.
  - Pending parameters are copied to the active set at the next period start. If the block is not running (disabled, or active set invalid), the copy happens on the cycle after the load.
- **Phase counter.** `ph` runs 0..P−1 and wraps. The wrap cycle is a period start.
  - Up is asserted for D ≤ ph < PulseLen.
  - Down is asserted for PulseLen + D ≤ ph < P.
  - Both are low otherwise, giving dead time at both transitions. Up and Down are never asserted together.
- **Coil FSM.** States are IDLE, ACTIVE and GUARD.
  - IDLE: at a period start, if `skipCnt` == 0 and W ≠ 0, the FSM toggles polarity, loads `workCnt` = W−1, reloads `skipCnt` = Skip, and enters ACTIVE. Otherwise `skipCnt` decrements, or reloads when it is 0 and W = 0.
  - ACTIVE: polarity A drives AU and BD; polarity B drives AD and BU. When `workCnt` reaches 0, `guardCnt` loads D and the FSM enters GUARD.
  - GUARD: all coil outputs are low; the FSM returns to IDLE when `guardCnt` reaches 0.
  - Overrun: if an activation slot falls while the FSM is in ACTIVE or GUARD, `o_coilOverrun` pulses, `skipCnt` reloads, and the current on-time is unaffected.
  - The first activation after reset uses polarity A.
- **Disable.** When `i_enable` goes low: `ph` = 0, coil FSM = IDLE, `skipCnt` = active Skip, and all drive outputs go low on the next edge. Polarity is kept. On re-enable, phase 0 is a period start.
- **Reset mid-operation.** Outputs go low asynchronously and the block returns to the reset state.

## Timing
- All outputs are registered.
- Drive outputs reflect `ph` with one cycle of latency.
- `o_periodStart` is coincident with the first drive cycle of the period.
- Load to active set: at most P cycles when running; 1 cycle when idle.
- A load on the same cycle as a period start goes to pending and applies at the following period start.
- Counters wrap modulo 2^CW only in the invalid case, which is unreachable after validation.

## Configuration
- `FAIMS_DRIVE_PARCHECK_EN` defined: the load validation above is enforced and `o_paramErr` is live.
- Macro undefined: every load is accepted and `o_paramErr` is tied to 0. With illegal parameters, outputs follow the phase comparisons literally; the Up/Down overlap guard is still enforced, and Down is forced low when Up is high.

## Structure
- Package `faims_pkg` holds:
  - the `coil_state_t` enum (IDLE, ACTIVE, GUARD);
  - the `faims_par_t` struct (period, pulse, dead, skip, work);
  - default widths CW = 16, SKW = 8, DW = 8.
- Sub-module `faims_coil_ctl` contains the coil FSM, skip/work/guard counters and polarity. Its inputs are the period-start strobe and the active parameters; its outputs are the four gate drives and `o_coilOverrun`.

## Test plan
- Load P=20, PulseLen=8, D=2, W=0, with enable high:
  - Up is high at phases 2..7, Down at 10..19.
  - Phases 0..1 and 8..9 are both low.
  - `o_periodStart` pulses every 20 cycles.
- Load P=20, PulseLen=8, D=2, Skip=1, W=5:
  - the coil is active for 5 cycles every 40 cycles;
  - polarity alternates A, B, A;
  - the first activation drives AU and BD;
  - GUARD keeps the outputs low for 2 cycles.
- Load W=50, P=20, Skip=0: `o_coilOverrun` pulses at the period starts that fall inside ACTIVE or GUARD, and no polarity toggles occur there.
- Load invalid PulseLen=19, D=2, P=20 with the macro defined: `o_paramErr` pulses 1 cycle and the waveform is unchanged.
- Load new P=30 mid-period: the old P=20 period completes, and the next period is 30 cycles.
- Assert `i_reset_n` low mid-ACTIVE: all outputs are 0 immediately. After release and a load, outputs stay low until enable, and the first coil polarity is A.
